// File: rtl/mem_pkg.sv
// Shared types and access-size helpers for the memory-access pipeline stage.
package mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and sign/zero extends.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;
  logic        sext;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    sext    = ~funct3[2];
    case (funct3[1:0])
      SZ_B:    result = {{56{sext & shifted[7]}},  shifted[7:0]};
      SZ_H:    result = {{48{sext & shifted[15]}}, shifted[15:0]};
      SZ_W:    result = {{32{sext & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack port, stalls upstream while
// an access is outstanding, and registers the writeback-bound result for forwarding.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [63:0]       alu_result_i,
  input  logic [63:0]       wr_ram_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [7:0]        dmem_be_o,
  output logic [63:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [63:0]       dmem_rdata_i,
  output logic              stall_o,
  output logic [63:0]       mem_result_o,
  output logic [4:0]        mem_rd_o,
  output logic              mem_reg_write_o,
  output logic              exc_misaligned_o
);

  state_t state_p1, state_d;

  logic        is_mem, is_store, misal, accept_mem;
  logic [2:0]  offset;

  // Access context captured at the accepting edge, used on the ack edge.
  logic [2:0]  funct3_p1;
  logic [2:0]  offset_p1;
  logic        is_load_p1;
  logic        reg_write_p1;
  logic [4:0]  rd_p1;
  logic [63:0] load_data;

  assign is_mem     = mem_read_i | mem_write_i;
  assign is_store   = mem_write_i;
  assign offset     = alu_result_i[2:0];
  assign misal      = is_misaligned(funct3_i[1:0], offset);
  assign accept_mem = (state_p1 == IDLE) && valid_i && is_mem && !misal;
  assign stall_o    = (state_p1 == ACCESS);

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .offset (offset_p1),
    .funct3 (funct3_p1),
    .result (load_data)
  );

  always_comb begin
    state_d = state_p1;
    case (state_p1)
      IDLE:    if (accept_mem) state_d = ACCESS;
      ACCESS:  if (dmem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_p1 <= IDLE;
    else       state_p1 <= state_d;
  end

  // ---- p0 -> p1: accept from Execute / complete memory access ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_req_o       <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_be_o        <= '0;
      dmem_wdata_o     <= '0;
      mem_result_o     <= '0;
      mem_rd_o         <= '0;
      mem_reg_write_o  <= 1'b0;
      exc_misaligned_o <= 1'b0;
      funct3_p1        <= '0;
      offset_p1        <= '0;
      is_load_p1       <= 1'b0;
      reg_write_p1     <= 1'b0;
      rd_p1            <= '0;
    end else if (state_p1 == IDLE) begin
      exc_misaligned_o <= 1'b0;
      mem_reg_write_o  <= 1'b0;
      if (valid_i && !is_mem) begin
        mem_result_o    <= alu_result_i;
        mem_rd_o        <= rd_i;
        mem_reg_write_o <= reg_write_i;
      end else if (valid_i && misal) begin
        exc_misaligned_o <= 1'b1;
      end else if (accept_mem) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= is_store;
        dmem_addr_o  <= {alu_result_i[ADDR_W-1:3], 3'b000};
        dmem_be_o    <= is_store ? (size_mask(funct3_i[1:0]) << offset) : 8'hFF;
        dmem_wdata_o <= wr_ram_data_i << {offset, 3'b000};
        funct3_p1    <= funct3_i;
        offset_p1    <= offset;
        is_load_p1   <= !is_store;
        reg_write_p1 <= reg_write_i;
        rd_p1        <= rd_i;
      end
    end else if (dmem_ack_i) begin
      dmem_req_o <= 1'b0;
      dmem_we_o  <= 1'b0;
      mem_rd_o   <= rd_p1;
      if (is_load_p1) begin
        mem_result_o    <= load_data;
        mem_reg_write_o <= reg_write_p1;
      end else begin
        mem_reg_write_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops vs. a reference model.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, mem_read_i, mem_write_i, reg_write_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [63:0] alu_result_i, wr_ram_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [7:0]  dmem_be_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;
  logic        stall_o;
  logic [63:0] mem_result_o;
  logic [4:0]  mem_rd_o;
  logic        mem_reg_write_o, exc_misaligned_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  mem_stage #(.ADDR_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .funct3_i(funct3_i),
    .rd_i(rd_i), .alu_result_i(alu_result_i), .wr_ram_data_i(wr_ram_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .mem_result_o(mem_result_o),
    .mem_rd_o(mem_rd_o), .mem_reg_write_o(mem_reg_write_o),
    .exc_misaligned_o(exc_misaligned_o)
  );

  // Reference model: value a load should return, from size/sign rules directly.
  function automatic logic [63:0] ref_load(logic [63:0] rdata, logic [63:0] addr, logic [2:0] f3);
    int nbytes = 1 << f3[1:0];
    int off    = int'(addr % 8);
    logic [63:0] v    = rdata >> (8 * off);
    logic [63:0] keep;
    if (nbytes < 8) begin
      keep = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & keep;
      if (!f3[2] && v[8*nbytes-1]) v = v | ~keep;
    end
    return v;
  endfunction

  function automatic logic ref_misaligned(logic [63:0] addr, logic [2:0] f3);
    return (addr % (64'd1 << f3[1:0])) != 0;
  endfunction

  function automatic logic [7:0] ref_be(logic [63:0] addr, logic [2:0] f3);
    int nbytes = 1 << f3[1:0];
    int off    = int'(addr % 8);
    int m      = ((1 << nbytes) - 1) << off;
    return m[7:0];
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    valid_i = 0; mem_read_i = 0; mem_write_i = 0; reg_write_i = 0;
    funct3_i = 0; rd_i = 0; alu_result_i = 0; wr_ram_data_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    n_checks++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, mem_result_o,
         mem_rd_o, mem_reg_write_o, exc_misaligned_o} !== '0)
      $display("FAIL reset_outputs: some output nonzero (req=%b res=%h rd=%0d)", dmem_req_o, mem_result_o, mem_rd_o);
    else n_pass++;
    n_checks++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else n_pass++;
  endtask

  task automatic test_passthrough;
    valid_i = 1; reg_write_i = 1; rd_i = 5; alu_result_i = 64'h1234;
    tick();
    valid_i = 0;
    n_checks++;
    if (mem_result_o !== 64'h1234) $display("FAIL pass_result: got %h want 1234", mem_result_o); else n_pass++;
    n_checks++;
    if (mem_rd_o !== 5'd5) $display("FAIL pass_rd: got %0d want 5", mem_rd_o); else n_pass++;
    n_checks++;
    if (mem_reg_write_o !== 1'b1) $display("FAIL pass_rw: got %b want 1", mem_reg_write_o); else n_pass++;
    n_checks++;
    if (stall_o !== 1'b0) $display("FAIL pass_stall: got %b want 0", stall_o); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_lb_signed;
    int stalls = 0;
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b000; rd_i = 7; reg_write_i = 1; alu_result_i = 64'h1003;
    tick();
    n_checks++;
    if (dmem_addr_o !== 64'h1000 || dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_be_o !== 8'hFF)
      $display("FAIL lb_request: addr=%h req=%b we=%b be=%h want addr=1000 req=1 we=0 be=ff",
               dmem_addr_o, dmem_req_o, dmem_we_o, dmem_be_o);
    else n_pass++;
    for (int w = 0; w < 3; w++) begin
      if (stall_o) stalls++;
      tick();
    end
    dmem_ack_i = 1; dmem_rdata_i = 64'h0000_0000_8000_0000;
    if (stall_o) stalls++;
    tick();
    idle_inputs();
    n_checks++;
    if (stalls != 4) $display("FAIL lb_stall_cycles: got %0d want 4", stalls); else n_pass++;
    n_checks++;
    if (mem_result_o !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_result: got %h want ffffffffffffff80", mem_result_o);
    else n_pass++;
    n_checks++;
    if (mem_reg_write_o !== 1'b1 || mem_rd_o !== 5'd7 || stall_o !== 1'b0 || dmem_req_o !== 1'b0)
      $display("FAIL lb_complete: rw=%b rd=%0d stall=%b req=%b want 1 7 0 0", mem_reg_write_o, mem_rd_o, stall_o, dmem_req_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_sh_store;
    valid_i = 1; mem_write_i = 1; funct3_i = 3'b001; rd_i = 3; reg_write_i = 0;
    alu_result_i = 64'h2006; wr_ram_data_i = 64'hABCD;
    tick();
    n_checks++;
    if (dmem_be_o !== 8'hC0) $display("FAIL sh_be: got %h want c0", dmem_be_o); else n_pass++;
    n_checks++;
    if (dmem_wdata_o !== 64'hABCD_0000_0000_0000) $display("FAIL sh_wdata: got %h want abcd000000000000", dmem_wdata_o);
    else n_pass++;
    n_checks++;
    if (dmem_we_o !== 1'b1 || dmem_req_o !== 1'b1 || dmem_addr_o !== 64'h2000)
      $display("FAIL sh_req: we=%b req=%b addr=%h want 1 1 2000", dmem_we_o, dmem_req_o, dmem_addr_o);
    else n_pass++;
    dmem_ack_i = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (mem_reg_write_o !== 1'b0 || dmem_req_o !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL sh_complete: rw=%b req=%b stall=%b want 0 0 0", mem_reg_write_o, dmem_req_o, stall_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_misaligned;
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b010; reg_write_i = 1; rd_i = 9; alu_result_i = 64'h2002;
    tick();
    idle_inputs();
    n_checks++;
    if (exc_misaligned_o !== 1'b1) $display("FAIL mis_exc: got %b want 1", exc_misaligned_o); else n_pass++;
    n_checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_reg_write_o !== 1'b0)
      $display("FAIL mis_side: req=%b stall=%b rw=%b want 0 0 0", dmem_req_o, stall_o, mem_reg_write_o);
    else n_pass++;
    tick();
    n_checks++;
    if (exc_misaligned_o !== 1'b0 || dmem_req_o !== 1'b0)
      $display("FAIL mis_pulse: exc=%b req=%b want 0 0", exc_misaligned_o, dmem_req_o);
    else n_pass++;
  endtask

  task automatic test_reset_during_access;
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b011; reg_write_i = 1; rd_i = 11; alu_result_i = 64'h3000;
    tick();
    n_checks++;
    if (stall_o !== 1'b1 || dmem_req_o !== 1'b1) $display("FAIL rst_acc_enter: stall=%b req=%b want 1 1", stall_o, dmem_req_o);
    else n_pass++;
    rst_i = 1;
    tick();
    rst_i = 0;
    idle_inputs();
    dmem_ack_i = 1; dmem_rdata_i = 64'hDEAD_BEEF_0000_1111;
    n_checks++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, stall_o, mem_result_o, mem_rd_o, mem_reg_write_o} !== '0)
      $display("FAIL rst_acc_clear: req=%b stall=%b addr=%h rd=%0d want all 0", dmem_req_o, stall_o, dmem_addr_o, mem_rd_o);
    else n_pass++;
    tick();
    dmem_ack_i = 0;
    n_checks++;
    if (mem_result_o !== 64'd0 || mem_reg_write_o !== 1'b0 || mem_rd_o !== 5'd0 || stall_o !== 1'b0)
      $display("FAIL rst_acc_ack_ignored: res=%h rw=%b rd=%0d stall=%b want 0", mem_result_o, mem_reg_write_o, mem_rd_o, stall_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [63:0] da = 64'h0123_4567_89AB_CDEF;
    logic [63:0] db = 64'hFEDC_BA98_7654_3210;
    valid_i = 1; mem_read_i = 1; funct3_i = 3'b011; reg_write_i = 1; rd_i = 1; alu_result_i = 64'h100;
    tick();
    n_checks++;
    if (stall_o !== 1'b1) $display("FAIL b2b_stall1: got %b want 1", stall_o); else n_pass++;
    dmem_ack_i = 1; dmem_rdata_i = da;
    tick();
    n_checks++;
    if (mem_result_o !== da || stall_o !== 1'b0 || mem_rd_o !== 5'd1)
      $display("FAIL b2b_first: res=%h stall=%b rd=%0d want %h 0 1", mem_result_o, stall_o, mem_rd_o, da);
    else n_pass++;
    dmem_ack_i = 0; rd_i = 2; alu_result_i = 64'h108;
    tick();
    n_checks++;
    if (stall_o !== 1'b1 || mem_reg_write_o !== 1'b0)
      $display("FAIL b2b_stall2: stall=%b rw=%b want 1 0", stall_o, mem_reg_write_o);
    else n_pass++;
    dmem_ack_i = 1; dmem_rdata_i = db;
    tick();
    idle_inputs();
    n_checks++;
    if (mem_result_o !== db || stall_o !== 1'b0 || mem_rd_o !== 5'd2 || mem_reg_write_o !== 1'b1)
      $display("FAIL b2b_second: res=%h stall=%b rd=%0d rw=%b want %h 0 2 1", mem_result_o, stall_o, mem_rd_o, mem_reg_write_o, db);
    else n_pass++;
    tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      int          kind  = $urandom_range(0, 2);
      int          waits = $urandom_range(0, 3);
      logic [2:0]  f3    = 3'($urandom_range(0, 7));
      logic [63:0] addr  = {$urandom, $urandom};
      logic [63:0] wd    = {$urandom, $urandom};
      logic [63:0] rdat  = {$urandom, $urandom};
      logic [4:0]  rd    = 5'($urandom_range(0, 31));
      logic        rw    = 1'($urandom_range(0, 1));
      int          stalls = 0;
      if (kind == 2) f3[2] = 1'b0;
      if ($urandom_range(0, 2) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      valid_i = 1; funct3_i = f3; rd_i = rd; reg_write_i = rw; alu_result_i = addr; wr_ram_data_i = wd;
      mem_read_i  = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
      mem_write_i = (kind == 2);
      tick();
      if (kind == 0) begin
        n_checks++;
        if (mem_result_o !== addr || mem_rd_o !== rd || mem_reg_write_o !== rw || stall_o !== 1'b0)
          $display("FAIL rnd_alu[%0d]: res=%h rd=%0d rw=%b want %h %0d %b", i, mem_result_o, mem_rd_o, mem_reg_write_o, addr, rd, rw);
        else n_pass++;
      end else if (ref_misaligned(addr, f3)) begin
        n_checks++;
        if (exc_misaligned_o !== 1'b1 || dmem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_reg_write_o !== 1'b0)
          $display("FAIL rnd_misal[%0d]: exc=%b req=%b stall=%b rw=%b want 1 0 0 0", i, exc_misaligned_o, dmem_req_o, stall_o, mem_reg_write_o);
        else n_pass++;
      end else begin
        n_checks++;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== {addr[63:3], 3'b000} || dmem_we_o !== (kind == 2) ||
            dmem_be_o !== ((kind == 2) ? ref_be(addr, f3) : 8'hFF) ||
            (kind == 2 && dmem_wdata_o !== (wd << (8 * (addr % 8)))))
          $display("FAIL rnd_req[%0d]: req=%b we=%b addr=%h be=%h wdata=%h for addr=%h f3=%0d data=%h",
                   i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, addr, f3, wd);
        else n_pass++;
        for (int w = 0; w < waits; w++) begin
          if (stall_o) stalls++;
          tick();
        end
        dmem_ack_i = 1; dmem_rdata_i = rdat;
        if (stall_o) stalls++;
        tick();
        dmem_ack_i = 0; valid_i = 0;
        n_checks++;
        if (stalls != waits + 1 || stall_o !== 1'b0 || dmem_req_o !== 1'b0 || mem_rd_o !== rd)
          $display("FAIL rnd_done[%0d]: stalls=%0d want %0d stall=%b req=%b rd=%0d want %0d",
                   i, stalls, waits + 1, stall_o, dmem_req_o, mem_rd_o, rd);
        else n_pass++;
        n_checks++;
        if (kind == 2 ? (mem_reg_write_o !== 1'b0)
                      : (mem_result_o !== ref_load(rdat, addr, f3) || mem_reg_write_o !== rw))
          $display("FAIL rnd_wb[%0d]: res=%h rw=%b want %h %b (addr=%h f3=%0d rdata=%h)", i, mem_result_o,
                   mem_reg_write_o, ref_load(rdat, addr, f3), (kind == 2) ? 1'b0 : rw, addr, f3, rdat);
        else n_pass++;
      end
      idle_inputs();
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_lb_signed();
    test_sh_store();
    test_misaligned();
    test_reset_during_access();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that consumes the Execute stage's ALU result, store data and destination register and performs the load/store against a 64-bit data memory using a request/acknowledge handshake. It drives the stalls and the MEM-stage forwarding sources (result, rd, reg-write) back into Execute, and registers the writeback-bound result. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- ADDR_W, 64, address width of the data-memory port.

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  instruction present from Execute.
- mem_read_i  in  1  instruction is a load.
- mem_write_i  in  1  instruction is a store.
- reg_write_i  in  1  instruction writes rd.
- funct3_i  in  3  access size and signedness.
- rd_i  in  5  destination register.
- alu_result_i  in  64  effective address for loads and stores; result for all other instructions.
- wr_ram_data_i  in  64  store data, already forwarded.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  ADDR_W  doubleword-aligned address, with bits [2:0] = 0.
- dmem_be_o  out  8  byte enables.
- dmem_wdata_o  out  64  lane-aligned store data.
- dmem_ack_i  in  1  request complete; read data valid in the same cycle.
- dmem_rdata_i  in  64  read doubleword.
- stall_o  out  1  hold all upstream stages.
- mem_result_o  out  64  registered result; also the forwarding source for Execute.
- mem_rd_o  out  5  registered rd.
- mem_reg_write_o  out  1  registered write-enable.
- exc_misaligned_o  out  1  one-cycle misaligned-access flag.

## Operation
- The FSM has two states, IDLE and ACCESS.
- **IDLE, non-memory op:** on the edge where `valid_i` is high and the op is neither a load nor a store, the block registers:
  - `mem_result_o` ← `alu_result_i`
  - `mem_rd_o` ← `rd_i`
  - `mem_reg_write_o` ← `reg_write_i`
- **IDLE, memory op:** when `valid_i` is high and the op is a load or store, the block captures the address, data, funct3, rd, kind and reg_write, then moves to ACCESS.
  - On that edge `mem_reg_write_o` is set to 0, so no bubble is forwarded.
- **Load/store priority:** if `mem_read_i` and `mem_write_i` are both high, the op is a store.
- **Size:** funct3[1:0] selects the size: 00 byte, 01 half, 10 word, 11 double. For loads, funct3[2] = 1 selects zero-extension. Load funct3 = 111 is treated as a double.
- **Misalignment:** an access is misaligned when the address is not a multiple of its size. A misaligned access:
  - issues no request and stays in IDLE;
  - pulses `exc_misaligned_o` for one cycle;
  - sets `mem_reg_write_o` to 0.
- **Byte enables and write data:** with offset = addr[2:0], `dmem_be_o` = size mask << offset and `dmem_wdata_o` = `wr_ram_data_i` << (8·offset).
  - For loads, `dmem_be_o` is 0xFF and `dmem_we_o` is 0.
- **ACCESS:**
  - `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_be_o` and `dmem_wdata_o` are registered and held stable until the ack.
  - `stall_o` = (state == ACCESS), combinational.
- **Ack edge** (`dmem_ack_i` high in ACCESS):
  - load: `mem_result_o` ← extend(`dmem_rdata_i` >> 8·offset), with `mem_reg_write_o` ← captured reg_write;
  - store: `mem_reg_write_o` ← 0;
  - in both cases `mem_rd_o` ← captured rd, `dmem_req_o` ← 0 and the state returns to IDLE.
- **Ignored inputs:** `valid_i` is ignored in ACCESS, because upstream holds its instruction. `dmem_ack_i` is ignored in IDLE.
- **Reset:** all outputs go to 0 and the state to IDLE.
  - Reset during ACCESS drops `dmem_req_o` on that edge.
  - An ack arriving after reset is ignored.

## Timing
- **Non-memory op:** 1-cycle latency from the accepting edge to `mem_result_o`.
- **Memory request:** `dmem_req_o` is high starting the cycle after the accepting edge. The earliest legal ack is in that same cycle.
- **Load latency:** minimum 2 cycles from the accepting edge to a valid `mem_result_o`. Each additional wait cycle adds 1.
- **Stall:** `stall_o` is high for every ACCESS cycle, including the ack cycle. The next instruction is accepted on the first IDLE cycle after the ack.
- **Store completion:** a store completes on the ack edge and produces no writeback.
- **Misaligned op:** `exc_misaligned_o` is high exactly one cycle, the cycle after the accepting edge.

## Structure
- Package `mem_pkg`:
  - `state_t` enum {IDLE, ACCESS};
  - size constants SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11;
  - the function computing the size mask.
- Sub-module `load_align`: combinational shift by offset plus sign/zero extension of the load data. The FSM and registers stay in `mem_stage`.

## Test plan
- **Non-memory pass-through:** `alu_result_i` = 0x1234, rd = 5, reg_write = 1 → next cycle `mem_result_o` = 0x1234, `mem_rd_o` = 5, `mem_reg_write_o` = 1, `stall_o` = 0.
- **Signed byte load:** LB at addr 0x1003, ack after 3 wait cycles, `dmem_rdata_i` = 0x0000_0000_8000_0000 → `dmem_addr_o` = 0x1000, `stall_o` high 4 cycles, `mem_result_o` = 0xFFFF_FFFF_FFFF_FF80.
- **Halfword store:** SH at addr 0x2006, data 0xABCD → `dmem_be_o` = 0xC0, `dmem_wdata_o` = 0xABCD_0000_0000_0000, `dmem_we_o` = 1, `mem_reg_write_o` = 0.
- **Misaligned load:** LW at 0x2002 → no `dmem_req_o`, `exc_misaligned_o` = 1 for one cycle, `stall_o` = 0.
- **Reset during ACCESS:** pulse `rst_i` while in ACCESS, then raise `dmem_ack_i` the next cycle → `dmem_req_o` = 0, all outputs 0, state IDLE, ack ignored.
- **Back-to-back loads:** two LDs, each acked in its first cycle → results appear 2 cycles apart and `stall_o` is high exactly one cycle for each.
